// File: rtl/div_recombine.sv
// Rebuilds dividend = quo*dvs + rem by repeated addition, one add per clock, with start/done handshake.
// Optional cross-check of the rebuilt value and remainder range when DIV_CHECK_EN is defined.
module div_recombine #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] dvs,
  input  logic [W-1:0] rem,
`ifdef DIV_CHECK_EN
  input  logic [W-1:0] exp_dvd,
  output logic         mismatch,
  output logic         rem_err,
`endif
  output logic         busy,
  output logic         done,
  output logic [2*W:0] val
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_next_state;
  logic [2*W:0]   r_acc;
  logic [W-1:0]   r_cnt;
  logic [W-1:0]   r_dvs;
  logic           r_busy;
  logic           r_done;
  logic [2*W:0]   r_val;
  logic [2*W:0]   w_sum;

  assign w_sum = r_acc + {{(W+1){1'b0}}, r_dvs};

  always_comb begin
    // NOTE: default assigned before the case so every path drives the signal; no latch is inferred.
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_ACC;
      S_ACC:   if (r_cnt == '0) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

`ifdef DIV_CHECK_EN
  logic [W-1:0] r_exp;
  logic [W-1:0] r_rem;
  logic         r_mismatch;
  logic         r_rem_err;
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_dvs   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_val   <= '0;
`ifdef DIV_CHECK_EN
      r_exp      <= '0;
      r_rem      <= '0;
      r_mismatch <= 1'b0;
      r_rem_err  <= 1'b0;
`endif
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dvs  <= dvs;
            r_acc  <= {{(W+1){1'b0}}, rem};
            // A zero divisor contributes nothing, so it finishes on the same schedule as quo==0.
            r_cnt  <= (dvs == '0) ? '0 : quo;
            r_busy <= 1'b1;
`ifdef DIV_CHECK_EN
            r_exp  <= exp_dvd;
            r_rem  <= rem;
`endif
          end
        end
        S_ACC: begin
          if (r_cnt != '0) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_val  <= r_acc;
            r_done <= 1'b1;
`ifdef DIV_CHECK_EN
            r_mismatch <= (r_acc != {{(W+1){1'b0}}, r_exp});
            r_rem_err  <= (r_dvs != '0) && (r_rem >= r_dvs);
`endif
          end
        end
        S_DONE: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
        end
        default: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign val  = r_val;
`ifdef DIV_CHECK_EN
  assign mismatch = r_mismatch;
  assign rem_err  = r_rem_err;
`endif

endmodule

// File: tb/tb_div_recombine.sv
// Directed bench for div_recombine: reset abort, latency, zero operands, max operands, back-to-back.
// Checker flags are exercised too when DIV_CHECK_EN is defined.
module tb_div_recombine;

  localparam int W = 8;

  logic         clk;
  logic         rstn;
  logic         start;
  logic [W-1:0] quo;
  logic [W-1:0] dvs;
  logic [W-1:0] rem;
  logic         busy;
  logic         done;
  logic [2*W:0] val;
`ifdef DIV_CHECK_EN
  logic [W-1:0] exp_dvd;
  logic         mismatch;
  logic         rem_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  div_recombine #(.W(W)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .start   (start),
    .quo     (quo),
    .dvs     (dvs),
    .rem     (rem),
`ifdef DIV_CHECK_EN
    .exp_dvd (exp_dvd),
    .mismatch(mismatch),
    .rem_err (rem_err),
`endif
    .busy    (busy),
    .done    (done),
    .val     (val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation; lat = edges after the accept edge until done is seen (-1 on timeout).
  task automatic do_op(input logic [W-1:0] q, input logic [W-1:0] d, input logic [W-1:0] r,
                       input logic [W-1:0] e, input bit poke,
                       output int lat, output bit busy_ok);
    quo = q; dvs = d; rem = r;
`ifdef DIV_CHECK_EN
    exp_dvd = e;
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
    quo = 8'hA5; dvs = 8'h5A; rem = 8'h3C;
`ifdef DIV_CHECK_EN
    exp_dvd = 8'hC3;
`endif
    lat = -1;
    busy_ok = 1'b1;
    for (int k = 1; k <= 600; k++) begin
      tick();
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin
        lat = k;
        start = 1'b0;
        break;
      end
      start = poke && (k % 3 == 0);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    int lat;
    bit bok;
    int seen;
    rstn = 1'b0; start = 1'b0; quo = '0; dvs = '0; rem = '0;
`ifdef DIV_CHECK_EN
    exp_dvd = '0;
`endif
    tick(); tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if (val !== '0) begin n_err++; $display("FAIL reset_val got=%0d exp=0", val); end
    rstn = 1'b1;
    tick();
    do_op(8'd1, 8'd2, 8'd1, 8'd3, 1'b0, lat, bok);
    n_cmp++; if (val !== 17'd3) begin n_err++; $display("FAIL pre_reset_val got=%0d exp=3", val); end
    tick();
    quo = 8'd9; dvs = 8'd3; rem = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_acc_busy got=%b exp=1", busy); end
    rstn = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL abort_done got=%b exp=0", done); end
    n_cmp++; if (val !== '0) begin n_err++; $display("FAIL abort_val got=%0d exp=0", val); end
    tick(); tick();
    rstn = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL abort_no_done got=%0d active cycles exp=0", seen); end
  endtask

  task automatic test_basic();
    int lat;
    bit bok;
    do_op(8'd6, 8'd7, 8'd5, 8'd47, 1'b0, lat, bok);
    n_cmp++; if (lat != 7) begin n_err++; $display("FAIL basic_latency got=%0d exp=7", lat); end
    n_cmp++; if (val !== 17'd47) begin n_err++; $display("FAIL basic_val got=%0d exp=47", val); end
    n_cmp++; if (bok !== 1'b1) begin n_err++; $display("FAIL basic_busy got=0 exp=1 through E7"); end
    tick();
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0)
      begin n_err++; $display("FAIL basic_pulse got done=%b busy=%b exp=0/0", done, busy); end
    repeat (3) tick();
    n_cmp++; if (val !== 17'd47) begin n_err++; $display("FAIL basic_hold got=%0d exp=47", val); end
  endtask

  task automatic test_zero();
    int lat;
    bit bok;
    do_op(8'd0, 8'd9, 8'd4, 8'd4, 1'b0, lat, bok);
    n_cmp++; if (lat != 1) begin n_err++; $display("FAIL quo0_latency got=%0d exp=1", lat); end
    n_cmp++; if (val !== 17'd4) begin n_err++; $display("FAIL quo0_val got=%0d exp=4", val); end
    tick();
    do_op(8'd5, 8'd0, 8'd2, 8'd2, 1'b0, lat, bok);
    n_cmp++; if (lat != 1) begin n_err++; $display("FAIL dvs0_latency got=%0d exp=1", lat); end
    n_cmp++; if (val !== 17'd2) begin n_err++; $display("FAIL dvs0_val got=%0d exp=2", val); end
    tick();
  endtask

  task automatic test_max();
    int lat;
    bit bok;
    do_op(8'd255, 8'd255, 8'd255, 8'd0, 1'b1, lat, bok);
    n_cmp++; if (lat != 256) begin n_err++; $display("FAIL max_latency got=%0d exp=256", lat); end
    n_cmp++; if (val !== 17'd65280) begin n_err++; $display("FAIL max_val got=%0d exp=65280", val); end
    n_cmp++; if (bok !== 1'b1) begin n_err++; $display("FAIL max_busy got=0 exp=1 while accumulating"); end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    bit bok;
    do_op(8'd2, 8'd3, 8'd1, 8'd7, 1'b0, lat, bok);
    n_cmp++; if (lat != 3) begin n_err++; $display("FAIL b2b1_latency got=%0d exp=3", lat); end
    n_cmp++; if (val !== 17'd7) begin n_err++; $display("FAIL b2b1_val got=%0d exp=7", val); end
    tick();
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0)
      begin n_err++; $display("FAIL b2b_idle got done=%b busy=%b exp=0/0", done, busy); end
    do_op(8'd1, 8'd4, 8'd0, 8'd4, 1'b0, lat, bok);
    n_cmp++; if (lat != 2) begin n_err++; $display("FAIL b2b2_latency got=%0d exp=2", lat); end
    n_cmp++; if (val !== 17'd4) begin n_err++; $display("FAIL b2b2_val got=%0d exp=4", val); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL b2b2_pulse got=%b exp=0", done); end
  endtask

`ifdef DIV_CHECK_EN
  task automatic test_check();
    int lat;
    bit bok;
    do_op(8'd6, 8'd7, 8'd5, 8'd47, 1'b0, lat, bok);
    n_cmp++; if (mismatch !== 1'b0) begin n_err++; $display("FAIL chk_match got=%b exp=0", mismatch); end
    n_cmp++; if (rem_err !== 1'b0) begin n_err++; $display("FAIL chk_remok got=%b exp=0", rem_err); end
    tick();
    do_op(8'd6, 8'd7, 8'd5, 8'd48, 1'b0, lat, bok);
    n_cmp++; if (mismatch !== 1'b1) begin n_err++; $display("FAIL chk_mismatch got=%b exp=1", mismatch); end
    tick();
    do_op(8'd1, 8'd3, 8'd3, 8'd6, 1'b0, lat, bok);
    n_cmp++; if (rem_err !== 1'b1) begin n_err++; $display("FAIL chk_rem_err got=%b exp=1", rem_err); end
    n_cmp++; if (mismatch !== 1'b0) begin n_err++; $display("FAIL chk_match6 got=%b exp=0", mismatch); end
    repeat (3) tick();
    n_cmp++; if (rem_err !== 1'b1) begin n_err++; $display("FAIL chk_hold got=%b exp=1", rem_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_max();
    test_back_to_back();
`ifdef DIV_CHECK_EN
    test_check();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
